// File: rtl/opl3_pkg.sv
// Shared OPL3 constants and types used by the channel mixer.
package opl3_pkg;

    localparam int MIX_NUM_CHANNELS = 18;
    localparam int MIX_NUM_OUTPUTS  = 4;
    localparam int MIX_ATTEN_WIDTH  = 3;

    typedef enum logic [1:0] {
        MIX_IDLE  = 2'd0,
        MIX_READ  = 2'd1,
        MIX_DRAIN = 2'd2,
        MIX_DONE  = 2'd3
    } mix_state_t;

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation of an IN_W-bit value into OUT_W bits, with a clip flag.
module sat_clamp #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0] sat_o,
    output logic                    clip_o
);

    // Work in the wider of the two widths so any IN_W/OUT_W combination compares correctly.
    localparam int W = (IN_W > OUT_W) ? IN_W : OUT_W;

    logic signed [W-1:0] ext;
    logic signed [W-1:0] max_v;
    logic signed [W-1:0] min_v;

    assign ext   = W'(acc_i);
    assign max_v = W'(signed'({1'b0, {(OUT_W-1){1'b1}}}));
    assign min_v = W'(signed'({1'b1, {(OUT_W-1){1'b0}}}));

    always_comb begin
        sat_o  = OUT_W'(ext);
        clip_o = 1'b0;
        if (ext > max_v) begin
            sat_o  = OUT_W'(max_v);
            clip_o = 1'b1;
        end else if (ext < min_v) begin
            sat_o  = OUT_W'(min_v);
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/channel_mixer_n.sv
// Sums NUM_CHANNELS signed samples from a 1-cycle-latency memory into NUM_OUTPUTS
// saturating buses, with per-channel output mask and attenuation shift.
module channel_mixer_n
    import opl3_pkg::*;
#(
    parameter int NUM_CHANNELS = MIX_NUM_CHANNELS,
    parameter int NUM_OUTPUTS  = MIX_NUM_OUTPUTS,
    parameter int IN_WIDTH     = 14,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ATTEN_WIDTH  = MIX_ATTEN_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 sample_clk_en,
    input  logic                                 start,
    input  logic [NUM_CHANNELS*NUM_OUTPUTS-1:0]  chan_mask,
    input  logic [NUM_CHANNELS*ATTEN_WIDTH-1:0]  chan_atten,
    output logic                                 rd_en,
    output logic [$clog2(NUM_CHANNELS)-1:0]      rd_addr,
    input  logic [IN_WIDTH-1:0]                  rd_data,
    output logic                                 busy,
    output logic                                 out_valid,
    output logic [NUM_OUTPUTS*SAMPLE_WIDTH-1:0]  out_data,
    output logic [NUM_OUTPUTS-1:0]               clip,
    output logic [1:0]                           dbg_state_o
);

    localparam int ADDR_W    = $clog2(NUM_CHANNELS);
    localparam int ACC_WIDTH = IN_WIDTH + $clog2(NUM_CHANNELS) + 1;

    mix_state_t                              state_q, state_d;
    logic [ADDR_W-1:0]                       idx_q, idx_d;
    logic [NUM_CHANNELS*NUM_OUTPUTS-1:0]     mask_q, mask_d;
    logic [NUM_CHANNELS*ATTEN_WIDTH-1:0]     atten_q, atten_d;
    logic [NUM_OUTPUTS*ACC_WIDTH-1:0]        acc_q, acc_d;
    logic [NUM_OUTPUTS*SAMPLE_WIDTH-1:0]     out_data_q, out_data_d;
    logic [NUM_OUTPUTS-1:0]                  clip_q, clip_d;
    logic                                    out_valid_q, out_valid_d;

    logic [NUM_OUTPUTS*SAMPLE_WIDTH-1:0]     sat_val;
    logic [NUM_OUTPUTS-1:0]                  sat_clip;
    logic                                    acc_en;
    logic [ADDR_W-1:0]                       acc_ch;
    logic [ATTEN_WIDTH-1:0]                  atten_c;
    logic signed [ACC_WIDTH-1:0]             term;

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_clamp
        sat_clamp #(
            .IN_W  (ACC_WIDTH),
            .OUT_W (SAMPLE_WIDTH)
        ) u_sat_clamp (
            .acc_i  (acc_q[o*ACC_WIDTH +: ACC_WIDTH]),
            .sat_o  (sat_val[o*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .clip_o (sat_clip[o])
        );
    end

    // rd_data on this cycle belongs to the channel read one cycle earlier.
    always_comb begin
        acc_ch  = (state_q == MIX_DRAIN || idx_q == '0) ? idx_q : idx_q - 1'b1;
        atten_c = atten_q[acc_ch*ATTEN_WIDTH +: ATTEN_WIDTH];
        term    = ACC_WIDTH'($signed(rd_data)) >>> atten_c;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        atten_d     = atten_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        clip_d      = clip_q;
        out_valid_d = 1'b0;
        acc_en      = 1'b0;

        case (state_q)
            MIX_IDLE: begin
                if (start && !out_valid_q) begin
                    mask_d  = chan_mask;
                    atten_d = chan_atten;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MIX_READ;
                end
            end
            MIX_READ: begin
                acc_en = (idx_q != '0);
                if (idx_q == ADDR_W'(NUM_CHANNELS - 1)) begin
                    state_d = MIX_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            MIX_DRAIN: begin
                acc_en  = 1'b1;
                state_d = MIX_DONE;
            end
            MIX_DONE: begin
                out_data_d  = sat_val;
                clip_d      = sat_clip;
                out_valid_d = 1'b1;
                state_d     = MIX_IDLE;
            end
            default: state_d = MIX_IDLE;
        endcase

        if (acc_en) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                if (mask_q[acc_ch*NUM_OUTPUTS + o]) begin
                    acc_d[o*ACC_WIDTH +: ACC_WIDTH] = acc_q[o*ACC_WIDTH +: ACC_WIDTH] + term;
                end
            end
        end

        // A new sample period abandons whatever pass is in flight; published results stay.
        if (sample_clk_en) begin
            state_d     = MIX_IDLE;
            idx_d       = '0;
            acc_d       = '0;
            out_data_d  = out_data_q;
            clip_d      = clip_q;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MIX_IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            atten_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            clip_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            atten_q     <= atten_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            clip_q      <= clip_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rd_en       = (state_q == MIX_READ);
    assign rd_addr     = (state_q == MIX_READ) ? idx_q : '0;
    assign busy        = (state_q != MIX_IDLE) || out_valid_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign clip        = clip_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_channel_mixer_n.sv
// Self-checking bench for channel_mixer_n: directed vector table, random passes against a
// floor-division reference model, and hand-written abort / reset / re-start sequences.
module tb_channel_mixer_n;

    localparam int NC  = 18;
    localparam int NO  = 4;
    localparam int IW  = 14;
    localparam int SW  = 16;
    localparam int AW  = 3;
    localparam int ADW = $clog2(NC);
    localparam longint SMAX = (longint'(1) << (SW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (SW - 1));

    logic                clk = 1'b0;
    logic                reset_n;
    logic                sample_clk_en;
    logic                start;
    logic [NC*NO-1:0]    chan_mask;
    logic [NC*AW-1:0]    chan_atten;
    logic                rd_en;
    logic [ADW-1:0]      rd_addr;
    logic [IW-1:0]       rd_data;
    logic                busy;
    logic                out_valid;
    logic [NO*SW-1:0]    out_data;
    logic [NO-1:0]       clip;
    logic [1:0]          dbg_state;

    always #5 clk = ~clk;

    channel_mixer_n #(
        .NUM_CHANNELS (NC),
        .NUM_OUTPUTS  (NO),
        .IN_WIDTH     (IW),
        .SAMPLE_WIDTH (SW),
        .ATTEN_WIDTH  (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_clk_en (sample_clk_en),
        .start         (start),
        .chan_mask     (chan_mask),
        .chan_atten    (chan_atten),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .clip          (clip),
        .dbg_state_o   (dbg_state)
    );

    // Sample memory: a read requested in one cycle returns data in the next.
    logic [IW-1:0]  mem [NC];
    logic           pend_en = 1'b0;
    logic [ADW-1:0] pend_addr = '0;

    always @(negedge clk) begin
        pend_en   = rd_en;
        pend_addr = rd_addr;
    end

    always @(posedge clk) begin
        #1;
        if (pend_en === 1'b1) rd_data = mem[pend_addr];
    end

    int n_vec  = 0;
    int n_fail = 0;
    int exp_v [NO];
    bit exp_c [NO];
    int last_v [NO];
    bit last_c [NO];

    typedef struct {
        int fill;
        int mmode;   // 0: no channel, 1: channel 0 only, 2: every channel
        int atten;
        int exp_v;
        bit exp_c;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [31:0] get_out(input int o);
        logic signed [SW-1:0] v;
        v = out_data[o*SW +: SW];
        return 32'(v);
    endfunction

    // Reference: each term is floor(sample / 2**atten), summed per output, then clamped.
    task automatic model(input logic [NC*NO-1:0] m, input logic [NC*AW-1:0] a);
        longint s, v, d, q;
        for (int o = 0; o < NO; o++) begin
            s = 0;
            for (int c = 0; c < NC; c++) begin
                if (m[c*NO + o]) begin
                    v = longint'($signed(mem[c]));
                    d = longint'(1) << a[c*AW +: AW];
                    q = v / d;
                    if ((v % d) != 0 && v < 0) q = q - 1;
                    s = s + q;
                end
            end
            if (s > SMAX) begin
                exp_v[o] = int'(SMAX); exp_c[o] = 1'b1;
            end else if (s < SMIN) begin
                exp_v[o] = int'(SMIN); exp_c[o] = 1'b1;
            end else begin
                exp_v[o] = int'(s); exp_c[o] = 1'b0;
            end
        end
    endtask

    task automatic run_pass(input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_busy_start"}, 32'(busy), 1);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, cyc, NC + 3);
        check({tag, "_busy_at_valid"}, 32'(busy), 1);
        for (int o = 0; o < NO; o++) begin
            check($sformatf("%s_out%0d", tag, o), get_out(o), exp_v[o]);
            check($sformatf("%s_clip%0d", tag, o), 32'(clip[o]), 32'(exp_c[o]));
        end
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(out_valid), 0);
        check({tag, "_idle_after"}, 32'(busy), 0);
        last_v = exp_v;
        last_c = exp_c;
    endtask

    task automatic randomize_mem();
        for (int c = 0; c < NC; c++) mem[c] = IW'($urandom_range(0, (1 << IW) - 1));
    endtask

    task automatic randomize_cfg();
        for (int b = 0; b < NC*NO; b++) chan_mask[b] = 1'($urandom_range(0, 1));
        for (int c = 0; c < NC; c++) chan_atten[c*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
    endtask

    initial begin
        int k, ov;
        bit found;
        logic [NC*NO-1:0] m1;

        reset_n       = 1'b0;
        sample_clk_en = 1'b0;
        start         = 1'b0;
        chan_mask     = '0;
        chan_atten    = '0;
        rd_data       = '0;
        for (int c = 0; c < NC; c++) mem[c] = '0;

        tbl[0] = '{fill: 100,   mmode: 2, atten: 0, exp_v: 1800,   exp_c: 1'b0};
        tbl[1] = '{fill: 8191,  mmode: 2, atten: 0, exp_v: 32767,  exp_c: 1'b1};
        tbl[2] = '{fill: -8192, mmode: 2, atten: 0, exp_v: -32768, exp_c: 1'b1};
        tbl[3] = '{fill: -5,    mmode: 1, atten: 1, exp_v: -3,     exp_c: 1'b0};
        tbl[4] = '{fill: 100,   mmode: 2, atten: 7, exp_v: 0,      exp_c: 1'b0};
        tbl[5] = '{fill: -1,    mmode: 2, atten: 7, exp_v: -18,    exp_c: 1'b0};
        tbl[6] = '{fill: 1000,  mmode: 2, atten: 0, exp_v: 18000,  exp_c: 1'b0};
        tbl[7] = '{fill: 1234,  mmode: 0, atten: 0, exp_v: 0,      exp_c: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data_nonzero", 32'(|out_data), 0);
        check("rst_clip", 32'(clip), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < NC; c++) mem[c] = tbl[i].fill[IW-1:0];
            case (tbl[i].mmode)
                0:       chan_mask = '0;
                1:       begin chan_mask = '0; chan_mask[NO-1:0] = '1; end
                default: chan_mask = '1;
            endcase
            for (int c = 0; c < NC; c++) chan_atten[c*AW +: AW] = tbl[i].atten[AW-1:0];
            for (int o = 0; o < NO; o++) begin
                exp_v[o] = tbl[i].exp_v;
                exp_c[o] = tbl[i].exp_c;
            end
            run_pass($sformatf("tbl%0d", i));
        end

        // Random passes against the reference model
        for (int r = 0; r < 24; r++) begin
            randomize_mem();
            randomize_cfg();
            if (r % 4 == 0) chan_atten = '0;
            model(chan_mask, chan_atten);
            run_pass($sformatf("rnd%0d", r));
        end

        // Abort at READ index 5: no result, previous result kept
        randomize_mem();
        chan_mask  = '1;
        chan_atten = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 40) begin
            @(negedge clk);
            k++;
            if (rd_en === 1'b1 && rd_addr == ADW'(5)) found = 1'b1;
        end
        check("abort_reach_idx5", 32'(found), 1);
        sample_clk_en = 1'b1;
        @(posedge clk);
        #1 sample_clk_en = 1'b0;
        @(negedge clk);
        check("abort_rd_en", 32'(rd_en), 0);
        check("abort_busy", 32'(busy), 0);
        ov = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid === 1'b1) ov++;
        end
        check("abort_no_valid", ov, 0);
        for (int o = 0; o < NO; o++) begin
            check($sformatf("abort_hold_out%0d", o), get_out(o), last_v[o]);
            check($sformatf("abort_hold_clip%0d", o), 32'(clip[o]), 32'(last_c[o]));
        end

        // sample_clk_en wins over start in the same cycle
        @(negedge clk);
        start = 1'b1;
        sample_clk_en = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; sample_clk_en = 1'b0; end
        @(negedge clk);
        check("strobe_beats_start_busy", 32'(busy), 0);
        check("strobe_beats_start_rd_en", 32'(rd_en), 0);

        // Start held high through the pass with the mask changed mid-pass
        randomize_mem();
        randomize_cfg();
        m1 = chan_mask;
        model(m1, chan_atten);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 chan_mask = ~m1;
        ov = 0;
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ov++;
                for (int o = 0; o < NO; o++) begin
                    check($sformatf("repulse_out%0d", o), get_out(o), exp_v[o]);
                    check($sformatf("repulse_clip%0d", o), 32'(clip[o]), 32'(exp_c[o]));
                end
            end
            if (ov > 0 && start) begin
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        start = 1'b0;
        check("repulse_single_valid", ov, 1);
        check("repulse_idle", 32'(busy), 0);
        last_v = exp_v;
        last_c = exp_c;

        // Asynchronous reset in the middle of READ
        randomize_mem();
        chan_mask = '1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 40) begin
            @(negedge clk);
            k++;
            if (rd_en === 1'b1 && rd_addr == ADW'(3)) found = 1'b1;
        end
        check("areset_reach_idx3", 32'(found), 1);
        #2 reset_n = 1'b0;
        #1;
        check("areset_busy", 32'(busy), 0);
        check("areset_rd_en", 32'(rd_en), 0);
        check("areset_out_data_nonzero", 32'(|out_data), 0);
        check("areset_clip", 32'(clip), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < NC; c++) mem[c] = IW'(100);
        chan_mask  = '1;
        chan_atten = '0;
        for (int o = 0; o < NO; o++) begin
            exp_v[o] = 1800;
            exp_c[o] = 1'b0;
        end
        run_pass("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
